// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Request sizes, FSM states and the accept-time error check live here.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP,
        ERR
    } lsu_state_t;

    // Illegal size or an access that is not naturally aligned.
    function automatic logic req_error(input lsu_size_t size, input logic [1:0] lo);
        logic err;
        err = 1'b0;
        case (size)
            SZ_HALF: err = lo[0];
            SZ_WORD: err = (lo != 2'b00);
            SZ_ILL:  err = 1'b1;
            default: err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane steering: load extraction with sign/zero extension,
// and merging of sub-word store data into a full memory word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  lsu_size_t   size,
    input  logic        uns,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] l,
                                            input lsu_size_t s, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{l, 3'b000} +: 8];
        h = l[1] ? w[31:16] : w[15:0];
        case (s)
            SZ_BYTE: r = {{24{b[7] & ~u}}, b};
            SZ_HALF: r = {{16{h[15] & ~u}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] l, input lsu_size_t s);
        logic [31:0] m;
        m = w;
        case (s)
            SZ_BYTE: m[{l, 3'b000} +: 8] = wd[7:0];
            SZ_HALF: begin
                if (l[1]) m[31:16] = wd[15:0];
                else      m[15:0]  = wd[15:0];
            end
            default: m = wd;
        endcase
        return m;
    endfunction

    assign load_data  = extract(word, lane, size, uns);
    assign store_data = merge(word, wdata, lane, size);

endmodule

// File: rtl/load_store_unit.sv
// Data-side load/store unit: one request at a time, sub-word stores done as
// read-modify-write because the memory port only writes whole words.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] DATA_BASE      = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_busy_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t        state_q, state_d;
    logic              we_q;
    lsu_size_t         size_q;
    logic              uns_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       load_data;
    logic [31:0]       store_data;
    lsu_size_t         req_size;
    logic              accept;

    assign req_size = lsu_size_t'(req_size_i);
    assign accept   = (state_q == IDLE) && req_valid_i;

    lsu_byte_lane u_lane (
        .word       (mem_data_i),
        .wdata      (wdata_q),
        .lane       (addr_q[1:0]),
        .size       (size_q),
        .uns        (uns_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we_i;
                size_q  <= req_size;
                uns_q   <= req_unsigned_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
        end
    end

    // The counter defaults to zero, so it only survives while the state holds.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    data_d = '0;
                    if (req_error(req_size, req_addr_i[1:0])) begin
                        state_d = ERR;
                    end else if (!req_we_i) begin
                        state_d = LOAD;
                    end else if (req_size == SZ_WORD) begin
                        state_d = WRITE;
                        data_d  = req_wdata_i;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD, RMW_RD, WRITE: begin
                if (mem_busy_i) begin
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = ERR;
                        data_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (state_q == LOAD) begin
                    state_d = RESP;
                    data_d  = load_data;
                end else if (state_q == RMW_RD) begin
                    state_d = WRITE;
                    data_d  = store_data;
                end else begin
                    state_d = RESP;
                end
            end
            RESP, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Memory outputs come from registers only; busy never reaches wen.
    always_comb begin
        req_ready_o  = (state_q == IDLE);
        resp_valid_o = (state_q == RESP) || (state_q == ERR);
        resp_err_o   = (state_q == ERR);
        resp_rdata_o = ((state_q == RESP) && !we_q) ? data_q : 32'h0;
        mem_wen_o    = (state_q == WRITE);
        mem_data_o   = (state_q == WRITE) ? data_q : 32'h0;
        mem_addr_o   = 32'h0;
        if ((state_q == LOAD) || (state_q == RMW_RD) || (state_q == WRITE))
            mem_addr_o = (addr_q - DATA_BASE) & 32'hFFFF_FFFC;
    end

endmodule
